// File: rtl/window_sum_3.sv
// window_sum_3: registered, saturating sum of the three most recently accepted
// signed samples, with fill tracking, synchronous flush and a one-cycle
// result strobe for the downstream divide-by-3 stage.
module window_sum_3 #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    clear,
    output logic                    out_en,
    output logic signed [WIDTH-1:0] out,
    output logic                    sat,
    output logic                    full
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } state_t;

    // Clamp limits expressed at the widened sum width so the compare is exact.
    localparam logic signed [WIDTH+1:0] SumMax = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] SumMin = {3'b111, {(WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] s0_q, s1_q, s2_q;
    logic signed [WIDTH-1:0] s0_d, s1_d, s2_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    sat_q, sat_d;
    logic                    outEn_q, outEn_d;
    logic signed [WIDTH+1:0] sum;

    // Sum of the window as it will look after the shift, widened so that three
    // extreme samples can never overflow before saturation.
    always_comb begin
        sum = {{2{in[WIDTH-1]}}, in}
            + {{2{s0_q[WIDTH-1]}}, s0_q}
            + {{2{s1_q[WIDTH-1]}}, s1_q};
    end

    // Next-state logic: flush has priority, otherwise an accepted sample shifts
    // the window, advances the fill state and, once full, produces a result.
    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        out_d   = out_q;
        sat_d   = sat_q;
        outEn_d = 1'b0;

        if (clear) begin
            state_d = EMPTY;
            s0_d    = '0;
            s1_d    = '0;
            s2_d    = '0;
        end else if (in_valid) begin
            s2_d = s1_q;
            s1_d = s0_q;
            s0_d = in;

            case (state_q)
                EMPTY:     state_d = ONE;
                ONE:       state_d = TWO;
                TWO, FULL: state_d = FULL;
                default:   state_d = EMPTY;
            endcase

            if (state_d == FULL) begin
                outEn_d = 1'b1;
                if (sum > SumMax) begin
                    out_d = SumMax[WIDTH-1:0];
                    sat_d = 1'b1;
                end else if (sum < SumMin) begin
                    out_d = SumMin[WIDTH-1:0];
                    sat_d = 1'b1;
                end else begin
                    out_d = sum[WIDTH-1:0];
                    sat_d = 1'b0;
                end
            end
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            outEn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
            outEn_q <= outEn_d;
        end
    end

    assign out_en = outEn_q;
    assign out    = out_q;
    assign sat    = sat_q;
    assign full   = (state_q == FULL);

endmodule
